// File: rtl/uart_link_pkg.sv
// Shared types and constants for the Arduino sensor-board UART link.
// No ports: provides the controller state encoding, the reply header bytes,
// the reply length and a saturating 8-bit increment.
package uart_link_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        WAIT0 = 3'd2,
        SEND1 = 3'd3,
        WAIT1 = 3'd4,
        RECV  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [7:0] HDR0      = 8'hAA;
    localparam logic [7:0] HDR1      = 8'hBB;
    localparam int         FRAME_LEN = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/arduino_frame_collect.sv
// Reply frame collector: stores the first FRAME_LEN-1 reply bytes and flags
// the final byte together with the header verdict.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       hold the byte index at 0 (asserted whenever not receiving)
//   capture     a reply byte is present on data this cycle
//   data        reply byte from uart_rx
//   done        final byte of the frame is being captured this cycle
//   good        stored header matches HDR0/HDR1
//   heading     {byte2, byte3}
//   distance    {byte4, live byte5}
module arduino_frame_collect
    import uart_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  data,
    output logic        done,
    output logic        good,
    output logic [15:0] heading,
    output logic [15:0] distance
);

    localparam int LAST = FRAME_LEN - 1;

    logic [2:0] idx;
    logic [7:0] store [LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int i = 0; i < LAST; i++) store[i] <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (capture && (idx < 3'(LAST))) begin
            store[idx] <= data;
            idx        <= idx + 3'd1;
        end
    end

    // The last byte is never stored; it is consumed straight from the input
    // so the result can be published on the edge that samples it.
    assign done     = capture && (idx == 3'(LAST));
    assign good     = (store[0] == HDR0) && (store[1] == HDR1);
    assign heading  = {store[2], store[3]};
    assign distance = {store[4], data};

endmodule

// File: rtl/arduino_poll_ctrl.sv
// Request/response controller for the Arduino sensor board: periodically sends
// the 2-byte poll command, collects and validates the 6-byte reply, retries on
// timeout or bad header, and publishes heading/distance.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   enable_i                polling enable
//   tx_data_o, tx_start_o   byte and start pulse to uart_tx
//   tx_done_i               end-of-byte pulse from uart_tx
//   rx_data_i, rx_valid_i   byte and valid pulse from uart_rx
//   heading_o, distance_o   last good sample
//   sample_valid_o          one-cycle update strobe
//   link_up_o               link status
//   timeout_cnt_o           saturating count of timed-out attempts
//   bad_frame_cnt_o         saturating count of bad-header frames
//   state_o                 FSM state for debug
//
// state | meaning
// IDLE  | waiting for a pending poll
// SEND0 | start pulse for the first command byte
// WAIT0 | first byte in flight
// SEND1 | start pulse for the second command byte
// WAIT1 | second byte in flight
// RECV  | collecting the reply, timeout running
// FAIL  | attempt failed: retry or give up
module arduino_poll_ctrl
    import uart_link_pkg::*;
#(
    parameter int         POLL_CYCLES    = 5_000_000,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter int         MAX_RETRIES    = 3,
    parameter logic [7:0] CMD_B0         = 8'hAA,
    parameter logic [7:0] CMD_B1         = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [15:0] heading_o,
    output logic [15:0] distance_o,
    output logic        sample_valid_o,
    output logic        link_up_o,
    output logic [7:0]  timeout_cnt_o,
    output logic [7:0]  bad_frame_cnt_o,
    output logic [2:0]  state_o
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state, state_d;
    logic [PW-1:0]   poll_tmr;
    logic            pending;
    logic [TW-1:0]   to_tmr;
    logic [3:0]      retry;
    logic            launch, publish, bad_frame, timed_out, retry_inc, give_up;
    logic            capture, frm_done, frm_good;
    logic [15:0]     frm_heading, frm_distance;

    assign capture = (state == RECV) && rx_valid_i;
    assign state_o = state;

    arduino_frame_collect u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state != RECV),
        .capture  (capture),
        .data     (rx_data_i),
        .done     (frm_done),
        .good     (frm_good),
        .heading  (frm_heading),
        .distance (frm_distance)
    );

    // A wrap while a poll is already pending is simply absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_tmr <= '0;
            pending  <= 1'b0;
        end else if (!enable_i) begin
            poll_tmr <= '0;
            pending  <= 1'b0;
        end else begin
            if (poll_tmr == PW'(POLL_CYCLES - 1)) poll_tmr <= '0;
            else                                   poll_tmr <= poll_tmr + 1'b1;
            if (launch)                                 pending <= 1'b0;
            else if (poll_tmr == PW'(POLL_CYCLES - 1)) pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              to_tmr <= '0;
        else if (state != RECV)  to_tmr <= '0;
        else                     to_tmr <= to_tmr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        tx_data_o  = 8'h00;
        tx_start_o = 1'b0;
        launch     = 1'b0;
        publish    = 1'b0;
        bad_frame  = 1'b0;
        timed_out  = 1'b0;
        retry_inc  = 1'b0;
        give_up    = 1'b0;
        case (state)
            IDLE: begin
                if (pending && enable_i) begin
                    launch  = 1'b1;
                    state_d = SEND0;
                end
            end
            SEND0: begin
                tx_data_o  = CMD_B0;
                tx_start_o = 1'b1;
                state_d    = WAIT0;
            end
            WAIT0: begin
                tx_data_o = CMD_B0;
                if (tx_done_i) state_d = SEND1;
            end
            SEND1: begin
                tx_data_o  = CMD_B1;
                tx_start_o = 1'b1;
                state_d    = WAIT1;
            end
            WAIT1: begin
                tx_data_o = CMD_B1;
                if (tx_done_i) state_d = RECV;
            end
            RECV: begin
                // A final byte landing on the timeout cycle takes priority.
                if (frm_done) begin
                    if (frm_good) begin
                        publish = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_frame = 1'b1;
                        state_d   = FAIL;
                    end
                end else if (to_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    timed_out = 1'b1;
                    state_d   = FAIL;
                end
            end
            FAIL: begin
                if (({1'b0, retry} + 5'd1) < 5'(MAX_RETRIES)) begin
                    retry_inc = 1'b1;
                    state_d   = SEND0;
                end else begin
                    give_up = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry           <= '0;
            heading_o       <= 16'd0;
            distance_o      <= 16'd30;
            sample_valid_o  <= 1'b0;
            link_up_o       <= 1'b0;
            timeout_cnt_o   <= 8'd0;
            bad_frame_cnt_o <= 8'd0;
        end else begin
            sample_valid_o <= publish;
            if (publish || give_up) retry <= '0;
            else if (retry_inc)     retry <= retry + 4'd1;
            if (publish) begin
                heading_o  <= frm_heading;
                distance_o <= frm_distance;
                link_up_o  <= 1'b1;
            end else if (give_up) begin
                link_up_o <= 1'b0;
            end
            if (timed_out) timeout_cnt_o   <= sat_inc8(timeout_cnt_o);
            if (bad_frame) bad_frame_cnt_o <= sat_inc8(bad_frame_cnt_o);
        end
    end

endmodule

// File: tb/tb_arduino_poll_ctrl.sv
module tb_arduino_poll_ctrl;
    import uart_link_pkg::*;

    localparam int POLL    = 100;
    localparam int TIMEOUT = 50;
    localparam int RETRIES = 3;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_done_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [15:0] heading_o;
    logic [15:0] distance_o;
    logic        sample_valid_o;
    logic        link_up_o;
    logic [7:0]  timeout_cnt_o;
    logic [7:0]  bad_frame_cnt_o;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;

    arduino_poll_ctrl #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES    (RETRIES),
        .CMD_B0         (8'hAA),
        .CMD_B1         (8'h00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .tx_data_o       (tx_data_o),
        .tx_start_o      (tx_start_o),
        .tx_done_i       (tx_done_i),
        .rx_data_i       (rx_data_i),
        .rx_valid_i      (rx_valid_i),
        .heading_o       (heading_o),
        .distance_o      (distance_o),
        .sample_valid_o  (sample_valid_o),
        .link_up_o       (link_up_o),
        .timeout_cnt_o   (timeout_cnt_o),
        .bad_frame_cnt_o (bad_frame_cnt_o),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles waited until tx_start_o is seen, or -1 if the budget ran out.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (tx_start_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (tx_start_o !== 1'b1) n = -1;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (state_o !== IDLE && n < budget) begin
            tick();
            n++;
        end
        if (state_o !== IDLE) n = -1;
    endtask

    // Called while the SENDx state is visible: move to WAITx, then pulse tx_done_i.
    task automatic finish_byte();
        tick();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    // Runs the complete command pair from the first start pulse up to RECV.
    task automatic command_pair(input int budget, output int n);
        int m;
        wait_start(budget, n);
        if (n >= 0) begin
            finish_byte();
            wait_start(5, m);
            if (m < 0) n = -1;
            else finish_byte();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable_i = 1'b0; tx_done_i = 1'b0;
        rx_data_i = 8'h00; rx_valid_i = 1'b0;
        repeat (3) tick();
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); end
        total++; if (tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin bad++; $display("FAIL reset_tx: got start=%b data=%h want 0/00", tx_start_o, tx_data_o); end
        total++; if (heading_o !== 16'h0000 || distance_o !== 16'd30) begin bad++; $display("FAIL reset_sample: got %h/%0d want 0000/30", heading_o, distance_o); end
        total++; if (sample_valid_o !== 1'b0 || link_up_o !== 1'b0) begin bad++; $display("FAIL reset_flags: got valid=%b link=%b want 0/0", sample_valid_o, link_up_o); end
        total++; if (timeout_cnt_o !== 8'd0 || bad_frame_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", timeout_cnt_o, bad_frame_cnt_o); end
        rst_n = 1'b1;
        enable_i = 1'b1;
    endtask

    task automatic test_poll_good();
        int n;
        wait_start(300, n);
        total++; if (n != POLL + 1) begin bad++; $display("FAIL first_poll_latency: got %0d want %0d", n, POLL + 1); end
        total++; if (tx_data_o !== 8'hAA) begin bad++; $display("FAIL cmd_b0: got %h want AA", tx_data_o); end
        tick();
        total++; if (tx_start_o !== 1'b0 || tx_data_o !== 8'hAA || state_o !== WAIT0) begin bad++; $display("FAIL wait0: got start=%b data=%h state=%0d want 0/AA/%0d", tx_start_o, tx_data_o, state_o, WAIT0); end
        repeat (3) begin
            tick();
            total++; if (tx_start_o !== 1'b0) begin bad++; $display("FAIL start_in_flight: got %b want 0", tx_start_o); end
        end
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        total++; if (tx_start_o !== 1'b1 || tx_data_o !== 8'h00) begin bad++; $display("FAIL cmd_b1: got start=%b data=%h want 1/00", tx_start_o, tx_data_o); end
        finish_byte();
        total++; if (state_o !== RECV) begin bad++; $display("FAIL enter_recv: got %0d want %0d", state_o, RECV); end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h01); send_byte(8'h2C); send_byte(8'h00);
        total++; if (sample_valid_o !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", sample_valid_o); end
        send_byte(8'h64);
        total++; if (sample_valid_o !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", sample_valid_o); end
        total++; if (heading_o !== 16'h012C || distance_o !== 16'h0064) begin bad++; $display("FAIL good_sample: got %h/%h want 012C/0064", heading_o, distance_o); end
        total++; if (link_up_o !== 1'b1 || state_o !== IDLE) begin bad++; $display("FAIL good_link: got link=%b state=%0d want 1/0", link_up_o, state_o); end
        tick();
        total++; if (sample_valid_o !== 1'b0) begin bad++; $display("FAIL valid_width: got %b want 0", sample_valid_o); end
    endtask

    task automatic test_bad_then_good();
        int n;
        command_pair(300, n);
        total++; if (n < 0) begin bad++; $display("FAIL bad_cmd: got no command want command pair"); end
        send_byte(8'hAA); send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        total++; if (bad_frame_cnt_o !== 8'd1 || state_o !== FAIL) begin bad++; $display("FAIL bad_frame: got cnt=%0d state=%0d want 1/%0d", bad_frame_cnt_o, state_o, FAIL); end
        total++; if (sample_valid_o !== 1'b0 || heading_o !== 16'h012C || link_up_o !== 1'b1) begin bad++; $display("FAIL bad_hold: got valid=%b hdg=%h link=%b want 0/012C/1", sample_valid_o, heading_o, link_up_o); end
        wait_start(5, n);
        total++; if (n != 1) begin bad++; $display("FAIL retry_latency: got %0d want 1", n); end
        command_pair(5, n);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        total++; if (sample_valid_o !== 1'b1 || heading_o !== 16'h1234 || distance_o !== 16'h5678) begin bad++; $display("FAIL retry_sample: got valid=%b %h/%h want 1 1234/5678", sample_valid_o, heading_o, distance_o); end
        total++; if (link_up_o !== 1'b1 || bad_frame_cnt_o !== 8'd1) begin bad++; $display("FAIL retry_link: got link=%b cnt=%0d want 1/1", link_up_o, bad_frame_cnt_o); end
    endtask

    task automatic test_timeout();
        int n;
        wait_start(300, n);
        total++; if (n < 0) begin bad++; $display("FAIL to_launch: got no start want start"); end
        for (int a = 0; a < RETRIES; a++) begin
            total++; if (tx_data_o !== 8'hAA) begin bad++; $display("FAIL to_cmd_b0: attempt %0d got %h want AA", a, tx_data_o); end
            finish_byte();
            wait_start(5, n);
            total++; if (tx_data_o !== 8'h00 || n < 0) begin bad++; $display("FAIL to_cmd_b1: attempt %0d got %h wait=%0d want 00", a, tx_data_o, n); end
            finish_byte();
            if (a < RETRIES - 1) begin
                wait_start(100, n);
                total++; if (n != TIMEOUT + 1) begin bad++; $display("FAIL to_resend: attempt %0d got %0d want %0d", a, n, TIMEOUT + 1); end
            end
        end
        wait_idle(100, n);
        total++; if (n != TIMEOUT + 1) begin bad++; $display("FAIL to_giveup: got %0d want %0d", n, TIMEOUT + 1); end
        total++; if (timeout_cnt_o !== 8'd3 || link_up_o !== 1'b0) begin bad++; $display("FAIL to_status: got cnt=%0d link=%b want 3/0", timeout_cnt_o, link_up_o); end
        total++; if (heading_o !== 16'h1234 || distance_o !== 16'h5678) begin bad++; $display("FAIL to_hold: got %h/%h want 1234/5678", heading_o, distance_o); end
    endtask

    task automatic test_same_cycle();
        int n;
        command_pair(300, n);
        total++; if (n < 0) begin bad++; $display("FAIL sc_cmd: got no command want command pair"); end
        repeat (TIMEOUT - 6) tick();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        total++; if (sample_valid_o !== 1'b1 || heading_o !== 16'h0A0B || distance_o !== 16'h0C0D) begin bad++; $display("FAIL sc_sample: got valid=%b %h/%h want 1 0A0B/0C0D", sample_valid_o, heading_o, distance_o); end
        total++; if (timeout_cnt_o !== 8'd3 || state_o !== IDLE || link_up_o !== 1'b1) begin bad++; $display("FAIL sc_status: got cnt=%0d state=%0d link=%b want 3/0/1", timeout_cnt_o, state_o, link_up_o); end
    endtask

    task automatic test_enable_drop();
        int n;
        wait_start(300, n);
        finish_byte();
        wait_start(5, n);
        tick();
        enable_i = 1'b0;
        total++; if (state_o !== WAIT1) begin bad++; $display("FAIL ed_wait1: got %0d want %0d", state_o, WAIT1); end
        tick();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        total++; if (state_o !== RECV) begin bad++; $display("FAIL ed_recv: got %0d want %0d", state_o, RECV); end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
        total++; if (sample_valid_o !== 1'b1 || heading_o !== 16'h0010 || distance_o !== 16'h0020) begin bad++; $display("FAIL ed_sample: got valid=%b %h/%h want 1 0010/0020", sample_valid_o, heading_o, distance_o); end
        wait_start(3 * POLL, n);
        total++; if (n != -1 || state_o !== IDLE) begin bad++; $display("FAIL ed_no_poll: got wait=%0d state=%0d want -1/0", n, state_o); end
        enable_i = 1'b1;
    endtask

    task automatic test_async_reset();
        int n;
        int hits;
        command_pair(300, n);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (state_o !== IDLE || tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin bad++; $display("FAIL ar_state: got state=%0d start=%b data=%h want 0/0/00", state_o, tx_start_o, tx_data_o); end
        total++; if (heading_o !== 16'h0000 || distance_o !== 16'd30 || link_up_o !== 1'b0) begin bad++; $display("FAIL ar_sample: got %h/%0d link=%b want 0000/30/0", heading_o, distance_o, link_up_o); end
        total++; if (timeout_cnt_o !== 8'd0 || bad_frame_cnt_o !== 8'd0) begin bad++; $display("FAIL ar_cnt: got %0d/%0d want 0/0", timeout_cnt_o, bad_frame_cnt_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h88); send_byte(8'h99); send_byte(8'hAA);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (sample_valid_o !== 1'b0 || tx_start_o !== 1'b0) hits++;
            tick();
        end
        total++; if (hits != 0 || state_o !== IDLE) begin bad++; $display("FAIL ar_release: got hits=%0d state=%0d want 0/0", hits, state_o); end
    endtask

    initial begin
        test_reset();
        test_poll_good();
        test_bad_then_good();
        test_timeout();
        test_same_cycle();
        test_enable_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
